// File: rtl/sysctrl_reg_arbiter_if.sv
// Bus bundle for the sysctrl register arbiter: Wishbone slave, housekeeping SPI
// access port and the shared byte-wide register port.
interface sysctrl_reg_arbiter_if #(parameter int ADDR_W = 8);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [3:0]        wb_sel_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;

  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [7:0]        spi_wdata;
  logic [7:0]        spi_rdata;
  logic              spi_ack;

  logic              reg_en;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;

  logic [1:0]        owner;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o,
    input  spi_req, spi_we, spi_addr, spi_wdata,
    output spi_rdata, spi_ack,
    output reg_en, reg_we, reg_addr, reg_wdata,
    input  reg_rdata,
    output owner
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o,
    output spi_req, spi_we, spi_addr, spi_wdata,
    input  spi_rdata, spi_ack,
    input  reg_en, reg_we, reg_addr, reg_wdata,
    output reg_rdata,
    input  owner
  );
endinterface

// File: rtl/sysctrl_reg_arbiter.sv
// Shares the byte-wide sysctrl register port between the Wishbone CPU (word
// accesses split into four byte beats) and the housekeeping SPI (single bytes).
module sysctrl_reg_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  sysctrl_reg_arbiter_if.slave bus
);
  localparam int LANES = 4;

  typedef enum logic [2:0] {IDLE, WB_ACC, WB_ACK, SPI_ACC, SPI_ACK} state_t;

  state_t                 state, nxt_state;
  logic [1:0]             k, nxt_k;
  logic                   last_spi;
  logic                   wb_req, grant_wb, grant_spi;

  logic                   q_we;
  logic [3:0]             q_sel;
  logic [ADDR_W-3:0]      q_adr;
  logic [LANES-1:0][7:0]  q_dat;

  logic                   src_we;
  logic [3:0]             src_sel;
  logic [ADDR_W-3:0]      src_adr;
  logic [LANES-1:0][7:0]  src_dat;

  logic                   nxt_en, nxt_we;
  logic [ADDR_W-1:0]      nxt_addr;
  logic [7:0]             nxt_wdata;

  // one-stage read tracker: the beat issued this cycle returns data next cycle
  logic                   rd_vld, rd_spi;
  logic [1:0]             rd_lane;
  logic [LANES-1:0][7:0]  wb_dat_q;
  logic [7:0]             spi_rdata_q;

  assign wb_req    = bus.wb_cyc_i & bus.wb_stb_i;
  assign grant_wb  = wb_req & (~bus.spi_req | last_spi);
  assign grant_spi = bus.spi_req & ~grant_wb;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      k        <= '0;
      last_spi <= 1'b1;
      q_we     <= 1'b0;
      q_sel    <= '0;
      q_adr    <= '0;
      q_dat    <= '0;
    end else begin
      state <= nxt_state;
      k     <= nxt_k;
      if (state == IDLE && grant_wb) begin
        last_spi <= 1'b0;
        q_we     <= bus.wb_we_i;
        q_sel    <= bus.wb_sel_i;
        q_adr    <= bus.wb_adr_i[ADDR_W-1:2];
        q_dat    <= bus.wb_dat_i;
      end else if (state == IDLE && grant_spi) begin
        last_spi <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (grant_wb) nxt_state = WB_ACC;
               else if (grant_spi) nxt_state = SPI_ACC;
      WB_ACC:  if (!bus.wb_cyc_i) nxt_state = IDLE;
               else if (k == 2'd3) nxt_state = WB_ACK;
      WB_ACK:  nxt_state = IDLE;
      SPI_ACC: nxt_state = SPI_ACK;
      SPI_ACK: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    nxt_k = (state == WB_ACC && nxt_state == WB_ACC) ? k + 2'd1 : 2'd0;
  end

  // Register-port outputs are flopped, so the beat is formed from the next
  // state; on the granting edge the request fields come straight from the bus.
  always_comb begin
    src_we  = (state == IDLE) ? bus.wb_we_i              : q_we;
    src_sel = (state == IDLE) ? bus.wb_sel_i             : q_sel;
    src_adr = (state == IDLE) ? bus.wb_adr_i[ADDR_W-1:2] : q_adr;
    src_dat = (state == IDLE) ? bus.wb_dat_i             : q_dat;

    nxt_en    = 1'b0;
    nxt_we    = 1'b0;
    nxt_addr  = '0;
    nxt_wdata = '0;
    if (nxt_state == WB_ACC) begin
      nxt_en    = src_we ? src_sel[nxt_k] : 1'b1;
      nxt_we    = src_we;
      nxt_addr  = {src_adr, nxt_k};
      nxt_wdata = src_we ? src_dat[nxt_k] : 8'h00;
    end else if (nxt_state == SPI_ACC) begin
      nxt_en    = 1'b1;
      nxt_we    = bus.spi_we;
      nxt_addr  = bus.spi_addr;
      nxt_wdata = bus.spi_wdata;
    end

    bus.wb_ack_o = (state == WB_ACK);
    bus.spi_ack  = (state == SPI_ACK);
    case (state)
      WB_ACC, WB_ACK:   bus.owner = 2'b01;
      SPI_ACC, SPI_ACK: bus.owner = 2'b10;
      default:          bus.owner = 2'b00;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus.reg_en    <= 1'b0;
      bus.reg_we    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      rd_vld        <= 1'b0;
      rd_spi        <= 1'b0;
      rd_lane       <= '0;
    end else begin
      bus.reg_en    <= nxt_en;
      bus.reg_we    <= nxt_we;
      bus.reg_addr  <= nxt_addr;
      bus.reg_wdata <= nxt_wdata;
      rd_vld        <= bus.reg_en & ~bus.reg_we;
      rd_spi        <= (state == SPI_ACC);
      rd_lane       <= bus.reg_addr[1:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_dat_q    <= '0;
      spi_rdata_q <= '0;
    end else if (rd_vld) begin
      if (rd_spi && state == SPI_ACK)
        spi_rdata_q <= bus.reg_rdata;
      else if (!rd_spi && (state == WB_ACC || state == WB_ACK))
        wb_dat_q[rd_lane] <= bus.reg_rdata;
    end
  end

  // The final beat's data arrives during the ack cycle; forward it so the
  // word is complete while the ack is high.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign bus.wb_dat_o[8*j +: 8] =
      (state == WB_ACK && rd_vld && !rd_spi && rd_lane == 2'(j)) ? bus.reg_rdata : wb_dat_q[j];
  end

  assign bus.spi_rdata = (state == SPI_ACK && rd_vld) ? bus.reg_rdata : spi_rdata_q;

endmodule

// File: tb/tb_sysctrl_reg_arbiter.sv
// Directed bench for sysctrl_reg_arbiter with a byte-wide register bank model.
module tb_sysctrl_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sysctrl_reg_arbiter_if #(.ADDR_W(8)) bus ();

  sysctrl_reg_arbiter #(.ADDR_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // register bank: write on reg_en&reg_we, read data registered for next cycle
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.reg_en) begin
      if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
      else            bus.reg_rdata     <= mem[bus.reg_addr];
    end
  end

  int en_cnt = 0;
  int viol   = 0;
  int wr_cnt [4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    if (bus.reg_en) begin
      en_cnt <= en_cnt + 1;
      if (bus.reg_we) wr_cnt[bus.reg_addr[1:0]] <= wr_cnt[bus.reg_addr[1:0]] + 1;
    end
    if ((bus.reg_en && bus.owner == 2'b00) || (bus.wb_ack_o && bus.spi_ack))
      viol <= viol + 1;
  end

  task automatic wb_op(input logic we, input logic [3:0] sel, input logic [7:0] adr,
                       input logic [31:0] dat, output int lat, output logic [31:0] rd);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_sel_i = sel;  bus.wb_adr_i = adr;  bus.wb_dat_i = dat;
    lat = 0; rd = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin lat = i; rd = bus.wb_dat_o; break; end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
  endtask

  task automatic spi_op(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                        output int lat, output logic [7:0] rd);
    @(negedge clk);
    bus.spi_req = 1'b1; bus.spi_we = we; bus.spi_addr = adr; bus.spi_wdata = dat;
    lat = 0; rd = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.spi_ack) begin lat = i; rd = bus.spi_rdata; break; end
    end
    bus.spi_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.owner, bus.wb_ack_o, bus.spi_ack, bus.reg_en, bus.reg_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl owner=%b ack=%b%b en=%b we=%b want all 0",
                         bus.owner, bus.wb_ack_o, bus.spi_ack, bus.reg_en, bus.reg_we);
    end
    checks++;
    if ({bus.wb_dat_o, bus.spi_rdata, bus.reg_addr, bus.reg_wdata} !== 56'h0) begin
      errors++; $display("FAIL reset_data dat_o=%h spi_rdata=%h addr=%h wdata=%h want 0",
                         bus.wb_dat_o, bus.spi_rdata, bus.reg_addr, bus.reg_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_wb_word;
    int lat; logic [31:0] rd;
    wb_op(1'b1, 4'b1111, 8'h04, 32'h0A0B0C0D, lat, rd);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wb_wr_latency got %0d want 5", lat); end
    checks++;
    if ({mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]} !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL wb_wr_bytes got %h%h%h%h want 0a0b0c0d",
                         mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]);
    end
    wb_op(1'b0, 4'b0001, 8'h05, 32'h0, lat, rd);  // low adr bits and sel ignored on reads
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wb_rd_latency got %0d want 5", lat); end
    checks++;
    if (rd !== 32'h0A0B0C0D) begin errors++; $display("FAIL wb_rd_data got %h want 0a0b0c0d", rd); end
    @(negedge clk);
    checks++;
    if (bus.wb_dat_o !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL wb_dat_hold got %h want 0a0b0c0d", bus.wb_dat_o);
    end
  endtask

  task automatic test_byte_sel;
    int lat, e0; int w0 [4]; logic [31:0] rd; logic [3:0] mask;
    wb_op(1'b1, 4'b1111, 8'h08, 32'h11223344, lat, rd);
    e0 = en_cnt; w0 = wr_cnt;
    wb_op(1'b1, 4'b0101, 8'h08, 32'hFFFFFFFF, lat, rd);
    for (int i = 0; i < 4; i++) mask[i] = (wr_cnt[i] != w0[i]);
    checks++;
    if (en_cnt - e0 !== 2 || mask !== 4'b0101) begin
      errors++; $display("FAIL sel_reg_en beats=%0d lanes=%b want 2 lanes 0101", en_cnt - e0, mask);
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL sel_latency got %0d want 5", lat); end
    wb_op(1'b0, 4'b0000, 8'h08, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h11FF33FF) begin errors++; $display("FAIL sel_readback got %h want 11ff33ff", rd); end
  endtask

  task automatic test_spi;
    int lat; logic [7:0] rd;
    spi_op(1'b1, 8'h09, 8'h56, lat, rd);
    checks++;
    if (lat !== 2 || mem[8'h09] !== 8'h56) begin
      errors++; $display("FAIL spi_write lat=%0d mem=%h want 2 56", lat, mem[8'h09]);
    end
    spi_op(1'b0, 8'h09, 8'h00, lat, rd);
    checks++;
    if (lat !== 2 || rd !== 8'h56) begin
      errors++; $display("FAIL spi_read lat=%0d data=%h want 2 56", lat, rd);
    end
    spi_op(1'b1, 8'h0A, 8'h77, lat, rd);
    checks++;
    if (bus.spi_rdata !== 8'h56) begin
      errors++; $display("FAIL spi_rdata_hold got %h want 56", bus.spi_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    t1 = 0; t2 = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 8'h04;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        if (t1 == 0) t1 = c;
        else begin t2 = c; break; end
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    checks++;
    if (t1 !== 5 || t2 !== 11) begin
      errors++; $display("FAIL b2b_acks first=%0d second=%0d want 5 11", t1, t2);
    end
  endtask

  task automatic test_arbitration;
    logic [1:0] grants [6]; logic [1:0] prev; int ng, wb_done, spi_done;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    ng = 0; wb_done = 0; spi_done = 0; prev = 2'b00;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 8'h04;
    bus.spi_req = 1'b1;  bus.spi_we = 1'b0;   bus.spi_addr = 8'h09;
    for (int c = 0; c < 200 && (wb_done < 3 || spi_done < 3); c++) begin
      @(negedge clk);
      if (bus.owner != 2'b00 && prev == 2'b00 && ng < 6) begin grants[ng] = bus.owner; ng++; end
      prev = bus.owner;
      if (bus.wb_ack_o) begin
        wb_done++;
        if (wb_done == 3) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
      end
      if (bus.spi_ack) begin
        spi_done++;
        if (spi_done == 3) bus.spi_req = 1'b0;
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.spi_req = 1'b0;
    checks++;
    if (ng !== 6 || {grants[0], grants[1], grants[2], grants[3], grants[4], grants[5]} !== 12'b01_10_01_10_01_10) begin
      errors++; $display("FAIL rr_order n=%0d seq=%b%b%b%b%b%b want 011001100110", ng,
                         grants[0], grants[1], grants[2], grants[3], grants[4], grants[5]);
    end
    checks++;
    if (wb_done !== 3 || spi_done !== 3) begin
      errors++; $display("FAIL rr_done wb=%0d spi=%0d want 3 3", wb_done, spi_done);
    end
  endtask

  task automatic test_no_preempt;
    int t_wb, t_spi;
    t_wb = 0; t_spi = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 8'h20; bus.wb_dat_i = 32'h01020304;
    for (int c = 1; c <= 30 && t_spi == 0; c++) begin
      @(negedge clk);
      if (c == 2) begin bus.spi_req = 1'b1; bus.spi_we = 1'b0; bus.spi_addr = 8'h21; end
      if (bus.wb_ack_o) begin t_wb = c; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
      if (bus.spi_ack) begin t_spi = c; bus.spi_req = 1'b0; end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.spi_req = 1'b0;
    checks++;
    if (t_wb !== 5 || t_spi !== 8) begin
      errors++; $display("FAIL no_preempt wb_ack=%0d spi_ack=%0d want 5 8", t_wb, t_spi);
    end
    checks++;
    if (bus.spi_rdata !== 8'h03) begin
      errors++; $display("FAIL no_preempt_data got %h want 03", bus.spi_rdata);
    end
  endtask

  task automatic test_abort;
    int lat, acks; logic [31:0] rd;
    wb_op(1'b1, 4'hF, 8'h30, 32'h44332211, lat, rd);
    acks = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 8'h30; bus.wb_dat_i = 32'hDDCCBBAA;
    @(negedge clk); @(negedge clk);           // k=1 beat on the port now
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (bus.wb_ack_o) acks++; end
    checks++;
    if (acks !== 0 || {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} !== 32'h4433BBAA) begin
      errors++; $display("FAIL abort acks=%0d mem=%h%h%h%h want 0 4433bbaa", acks,
                         mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]);
    end
  endtask

  task automatic test_reset_mid;
    int lat, acks; logic [31:0] rd;
    wb_op(1'b1, 4'hF, 8'h10, 32'h44332211, lat, rd);
    wb_op(1'b0, 4'hF, 8'h10, 32'h0, lat, rd);  // leaves non-zero wb_dat_o
    acks = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = 8'h10; bus.wb_dat_i = 32'hDDCCBBAA;
    @(negedge clk); @(negedge clk);           // reset lands on the edge that would start k=2
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00 || bus.reg_en !== 1'b0 || bus.wb_dat_o !== 32'h0 || bus.wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out owner=%b en=%b dat=%h ack=%b want 00 0 0 0",
                         bus.owner, bus.reg_en, bus.wb_dat_o, bus.wb_ack_o);
    end
    rst = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (bus.wb_ack_o) acks++; end
    checks++;
    if (acks !== 0 || {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'h4433BBAA) begin
      errors++; $display("FAIL rst_mid_bytes acks=%0d mem=%h%h%h%h want 0 4433bbaa", acks,
                         mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]);
    end
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_sel_i = '0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
    bus.spi_req = 1'b0;  bus.spi_we = 1'b0;   bus.spi_addr = '0;  bus.spi_wdata = '0;
    bus.reg_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset;
    test_wb_word;
    test_byte_sel;
    test_spi;
    test_back_to_back;
    test_arbitration;
    test_no_preempt;
    test_abort;
    test_reset_mid;
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL port_ownership violations=%0d want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
